// File: rtl/trip_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rts_instr_pkg
// Shared definitions for the trip scan sequencer slice.
//   - channel mode encodings (2-bit; code 3 is reserved and never trips)
//   - default channel count and sensor/setpoint word width
//   - scan FSM state encoding
// -----------------------------------------------------------------------------
package rts_instr_pkg;

    localparam logic [1:0] MODE_BYPASS  = 2'd0;
    localparam logic [1:0] MODE_OPERATE = 2'd1;
    localparam logic [1:0] MODE_TRIP    = 2'd2;

    localparam int NCHANNELS = 3;
    localparam int W         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/trip_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// trip_scan_sequencer_if
// Request/result bundle between the sensor-sampling side (master) and the
// trip scan sequencer (slave).
//   start        scan request, honoured only while the sequencer is idle
//   vals         NChannels packed sensor words, channel 0 in the MS word
//   setpoints    NChannels packed setpoints, same packing as vals
//   modes        NChannels packed 2-bit modes, channel 0 in the MS pair
//   busy         scan in progress
//   done         one-cycle pulse when trip/sensor_trip are refreshed
//   trip         per-channel trip result, channel 0 at the MSB
//   sensor_trip  per-channel raw comparator result, channel 0 at the MSB
//   trip_reset   (only with TRIP_LATCH_EN) clears the sticky trip vector
// -----------------------------------------------------------------------------
interface trip_scan_sequencer_if #(
    parameter int NChannels = 3,
    parameter int W         = 32
);
    logic                      start;
    logic [NChannels*W-1:0]    vals;
    logic [NChannels*W-1:0]    setpoints;
    logic [NChannels*2-1:0]    modes;
    logic                      busy;
    logic                      done;
    logic [NChannels-1:0]      trip;
    logic [NChannels-1:0]      sensor_trip;
`ifdef TRIP_LATCH_EN
    logic                      trip_reset;

    modport master (
        output start, vals, setpoints, modes, trip_reset,
        input  busy, done, trip, sensor_trip
    );

    modport slave (
        input  start, vals, setpoints, modes, trip_reset,
        output busy, done, trip, sensor_trip
    );
`else
    modport master (
        output start, vals, setpoints, modes,
        input  busy, done, trip, sensor_trip
    );

    modport slave (
        input  start, vals, setpoints, modes,
        output busy, done, trip, sensor_trip
    );
`endif
endinterface

// File: rtl/trip_scan_sequencer_ch_trip_eval.sv
// -----------------------------------------------------------------------------
// ch_trip_eval
// Combinational single-channel trip evaluator; the sequencer time-shares one
// instance across all channels.
//   v      sensor reading (unsigned)
//   sp     setpoint (unsigned)
//   mode   channel mode (bypass / operate / force-trip / reserved)
//   is_lt  1: channel trips when v is below sp; 0: when v is above sp
//   s      raw comparator result, independent of mode
//   trip   mode-qualified trip result
// Equality never trips in either sense.
// -----------------------------------------------------------------------------
module ch_trip_eval #(
    parameter int W = 32
) (
    input  logic [W-1:0] v,
    input  logic [W-1:0] sp,
    input  logic [1:0]   mode,
    input  logic         is_lt,
    output logic         s,
    output logic         trip
);
    import rts_instr_pkg::*;

    assign s = is_lt ? (v < sp) : (sp < v);

    always_comb begin
        trip = 1'b0;
        case (mode)
            MODE_BYPASS:  trip = 1'b0;
            MODE_OPERATE: trip = s;
            MODE_TRIP:    trip = 1'b1;
            default:      trip = 1'b0;
        endcase
    end

endmodule

// File: rtl/trip_scan_sequencer.sv
// -----------------------------------------------------------------------------
// trip_scan_sequencer
// Time-multiplexed trip evaluator for one instrumentation division. A start
// request snapshots every channel's reading, setpoint and mode; the channels
// are then walked one per cycle through a single ch_trip_eval and the results
// are published together with a one-cycle done pulse.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   trip_scan_sequencer_if.slave (start, vals, setpoints, modes in;
//         busy, done, trip, sensor_trip out; trip_reset with TRIP_LATCH_EN)
//
// Build option: TRIP_LATCH_EN makes trip sticky (OR-accumulated across scans)
// and adds trip_reset, honoured only while idle. sensor_trip is never sticky.
//
// Timing: start sampled at edge t -> done high in the cycle after edge
// t+NChannels+1. busy covers the scan, the DONE state and the done cycle, so
// the earliest accepted restart is the cycle after done.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last scan
// SCAN  | evaluating channel idx from the snapshot into the shadow vectors
// DONE  | shadow vectors are copied to the outputs at the closing edge
// -----------------------------------------------------------------------------
module trip_scan_sequencer #(
    parameter int NChannels = rts_instr_pkg::NCHANNELS,
    parameter int W         = rts_instr_pkg::W,
    parameter int LTChannel = 2
) (
    input logic                   clk,
    input logic                   rst,
    trip_scan_sequencer_if.slave  bus
);
    import rts_instr_pkg::*;

    localparam int IdxW = (NChannels > 1) ? $clog2(NChannels) : 1;

    scan_state_t           state_q;
    scan_state_t           state_d;
    logic [IdxW-1:0]       idx_q;

    logic [W-1:0]          val_snap  [NChannels];
    logic [W-1:0]          sp_snap   [NChannels];
    logic [1:0]            mode_snap [NChannels];

    logic [NChannels-1:0]  sens_sh;
    logic [NChannels-1:0]  trip_sh;
    logic [NChannels-1:0]  sens_q;
    logic [NChannels-1:0]  trip_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  capture;
    logic                  scan_step;
    logic                  publish;
    logic                  last_ch;
    logic                  idle_ready;
    logic [IdxW-1:0]       bit_pos;

    logic [W-1:0]          cur_v;
    logic [W-1:0]          cur_sp;
    logic [1:0]            cur_mode;
    logic                  cur_is_lt;
    logic                  cur_s;
    logic                  cur_trip;

    // The done cycle is already IDLE but still reported busy; gating on
    // busy_q keeps start/trip_reset from being honoured in that cycle.
    assign idle_ready = (state_q == IDLE) && !busy_q;
    assign last_ch    = (32'(idx_q) == NChannels - 1);
    assign bit_pos    = IdxW'(NChannels - 1) - idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        scan_step = 1'b0;
        publish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && idle_ready) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_step = 1'b1;
                if (last_ch) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_v     = val_snap[idx_q];
        cur_sp    = sp_snap[idx_q];
        cur_mode  = mode_snap[idx_q];
        cur_is_lt = (32'(idx_q) == LTChannel);
    end

    ch_trip_eval #(
        .W(W)
    ) u_eval (
        .v     (cur_v),
        .sp    (cur_sp),
        .mode  (cur_mode),
        .is_lt (cur_is_lt),
        .s     (cur_s),
        .trip  (cur_trip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            sens_sh <= '0;
            trip_sh <= '0;
            sens_q  <= '0;
            trip_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NChannels; i++) begin
                val_snap[i]  <= '0;
                sp_snap[i]   <= '0;
                mode_snap[i] <= '0;
            end
        end else begin
            done_q <= publish;
            busy_q <= (state_d != IDLE) || (state_q == DONE);

            if (capture) begin
                idx_q   <= '0;
                sens_sh <= '0;
                trip_sh <= '0;
                for (int i = 0; i < NChannels; i++) begin
                    val_snap[i]  <= bus.vals[(NChannels-1-i)*W +: W];
                    sp_snap[i]   <= bus.setpoints[(NChannels-1-i)*W +: W];
                    mode_snap[i] <= bus.modes[(NChannels-1-i)*2 +: 2];
                end
            end

            if (scan_step) begin
                sens_sh[bit_pos] <= cur_s;
                trip_sh[bit_pos] <= cur_trip;
                idx_q            <= last_ch ? '0 : idx_q + 1'b1;
            end

            if (publish) begin
                sens_q <= sens_sh;
`ifdef TRIP_LATCH_EN
                trip_q <= trip_q | trip_sh;
`else
                trip_q <= trip_sh;
`endif
            end

`ifdef TRIP_LATCH_EN
            // Clear and capture may share an edge: the cleared vector is what
            // the new scan later ORs into.
            if (bus.trip_reset && idle_ready) begin
                trip_q <= '0;
            end
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.trip        = trip_q;
    assign bus.sensor_trip = sens_q;

endmodule

// File: tb/tb_trip_scan_sequencer.sv
module tb_trip_scan_sequencer;

    localparam int NCH = 3;
    localparam int WW  = 32;

    logic clk;
    logic rst;

    trip_scan_sequencer_if #(.NChannels(NCH), .W(WW)) bus ();

    trip_scan_sequencer #(
        .NChannels (NCH),
        .W         (WW),
        .LTChannel (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [2*NCH-1:0] exp_q [$];
    logic [NCH-1:0]   last_trip;
    logic [NCH-1:0]   last_sens;
    logic [NCH-1:0]   trip_acc;

    logic [WW-1:0] cv  [NCH];
    logic [WW-1:0] csp [NCH];
    logic [1:0]    cm  [NCH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference evaluation straight from the channel rules.
    task automatic model(output logic [NCH-1:0] tr, output logic [NCH-1:0] se);
        logic s;
        tr = '0;
        se = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (ch == 2) s = (cv[ch] < csp[ch]);
            else         s = (cv[ch] > csp[ch]);
            se[NCH-1-ch] = s;
            tr[NCH-1-ch] = (cm[ch] == 2'd2) || ((cm[ch] == 2'd1) && s);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [2*NCH-1:0] e;
                e = exp_q.pop_front();
                check_val("trip", 32'(bus.trip), 32'(e[2*NCH-1:NCH]));
                check_val("sensor_trip", 32'(bus.sensor_trip), 32'(e[NCH-1:0]));
            end
        end
    end

    // mid: 0 plain, 1 change inputs + restart pulse during scan,
    //      2 trip_reset during scan, 3 trip_reset together with start
    task automatic do_scan(input int mid);
        logic [NCH-1:0] tr, se;
        int cycles;
        model(tr, se);
`ifdef TRIP_LATCH_EN
        if (mid == 3) trip_acc = '0;
        trip_acc = trip_acc | tr;
        tr = trip_acc;
`endif
        exp_q.push_back({tr, se});
        last_trip = tr;
        last_sens = se;

        @(negedge clk);
        bus.vals      = {cv[0], cv[1], cv[2]};
        bus.setpoints = {csp[0], csp[1], csp[2]};
        bus.modes     = {cm[0], cm[1], cm[2]};
        bus.start     = 1'b1;
`ifdef TRIP_LATCH_EN
        if (mid == 3) bus.trip_reset = 1'b1;
`endif
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                bus.start = 1'b0;
                check_val("busy_in_scan", 32'(bus.busy), 32'd1);
                if (mid == 1) begin
                    bus.vals      = ~bus.vals;
                    bus.setpoints = ~bus.setpoints;
                    bus.modes     = ~bus.modes;
                    bus.start     = 1'b1;
                end
`ifdef TRIP_LATCH_EN
                bus.trip_reset = (mid == 2);
                if (mid == 3) check_val("clear_with_start", 32'(bus.trip), 32'd0);
`endif
            end else if (cycles == 2) begin
                bus.start = 1'b0;
`ifdef TRIP_LATCH_EN
                bus.trip_reset = 1'b0;
`endif
            end
        end while (bus.done !== 1'b1 && cycles < 40);
        check_val("latency", 32'(cycles), 32'(NCH + 2));
        @(negedge clk);
        check_val("done_one_cycle", 32'(bus.done), 32'd0);
        check_val("busy_after_done", 32'(bus.busy), 32'd0);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int done_before;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.vals      = '0;
        bus.setpoints = '0;
        bus.modes     = '0;
`ifdef TRIP_LATCH_EN
        bus.trip_reset = 1'b0;
`endif
        trip_acc  = '0;
        last_trip = '0;
        last_sens = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_trip", 32'(bus.trip), 32'd0);
        check_val("rst_sensor_trip", 32'(bus.sensor_trip), 32'd0);
        rst = 1'b0;

        // operate compare
        cv = '{32'd200, 32'd50, 32'd10}; csp = '{32'd100, 32'd100, 32'd20}; cm = '{2'd1, 2'd1, 2'd1};
        do_scan(0);
        repeat (3) @(negedge clk);
        check_val("trip_hold", 32'(bus.trip), 32'(last_trip));
        check_val("sensor_hold", 32'(bus.sensor_trip), 32'(last_sens));

        // equality and word extremes
        cv = '{32'd100, 32'd0, 32'hFFFF_FFFF}; csp = '{32'd100, 32'hFFFF_FFFF, 32'd0};
        do_scan(0);
        cv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}; csp = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        do_scan(0);

        // mode mix: bypass, force-trip, reserved
        cv = '{32'd200, 32'd200, 32'd0}; csp = '{32'd100, 32'd100, 32'd50}; cm = '{2'd0, 2'd2, 2'd3};
        do_scan(0);

        // inputs change and a second start arrives while scanning
        cv = '{32'd5, 32'd500, 32'd7}; csp = '{32'd9, 32'd400, 32'd3}; cm = '{2'd1, 2'd1, 2'd1};
        do_scan(1);
        repeat (6) @(negedge clk);
        check_val("no_queued_start", 32'(bus.busy), 32'd0);

        // reset while idx == 1
        @(negedge clk);
        bus.vals      = {32'd200, 32'd200, 32'd0};
        bus.setpoints = {32'd100, 32'd100, 32'd50};
        bus.modes     = {2'd1, 2'd1, 2'd1};
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        trip_acc = '0;
        done_before = n_done;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_trip", 32'(bus.trip), 32'd0);
        check_val("abort_sensor_trip", 32'(bus.sensor_trip), 32'd0);
        repeat (8) @(negedge clk);
        check_val("abort_no_done", 32'(n_done - done_before), 32'd0);
        cv = '{32'd1, 32'd300, 32'd2}; csp = '{32'd2, 32'd200, 32'd9}; cm = '{2'd1, 2'd1, 2'd2};
        do_scan(0);

        // pseudo-random patterns over a small range to hit equality often
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NCH; c++) begin
                cv[c]  = 32'($urandom_range(0, 15));
                csp[c] = 32'($urandom_range(0, 15));
                cm[c]  = 2'($urandom_range(0, 3));
            end
            do_scan(0);
        end

`ifdef TRIP_LATCH_EN
        @(negedge clk);
        bus.trip_reset = 1'b1;
        @(negedge clk);
        bus.trip_reset = 1'b0;
        trip_acc = '0;
        check_val("latch_clear", 32'(bus.trip), 32'd0);
        cm = '{2'd1, 2'd1, 2'd1};
        cv = '{32'd200, 32'd0, 32'd50}; csp = '{32'd100, 32'd100, 32'd20};
        do_scan(0);
        cv = '{32'd0, 32'd0, 32'd10}; csp = '{32'd100, 32'd100, 32'd20};
        do_scan(0);
        check_val("latch_accum", 32'(bus.trip), 32'b101);
        do_scan(2);
        check_val("latch_reset_busy_ignored", 32'(bus.trip), 32'b101);
        @(negedge clk);
        bus.trip_reset = 1'b1;
        @(negedge clk);
        bus.trip_reset = 1'b0;
        trip_acc = '0;
        check_val("latch_clear_idle", 32'(bus.trip), 32'd0);
        cv = '{32'd200, 32'd0, 32'd50}; csp = '{32'd100, 32'd100, 32'd20};
        do_scan(0);
        cv = '{32'd0, 32'd0, 32'd10}; csp = '{32'd100, 32'd100, 32'd20};
        do_scan(3);
        check_val("latch_clear_then_capture", 32'(bus.trip), 32'b001);
`endif

        repeat (2) @(negedge clk);
        check_val("sb_final_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
